// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - command sequencer driving a 16-bit combinational ALU
// Holds an 8x16 register file and issues narrow (one pass) or wide (two carry-chained passes) operations.
module alu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_valid,
  input  logic [2:0]  ld_addr,
  input  logic [15:0] ld_data,
  input  logic [2:0]  rd_addr,
  output logic [15:0] rd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_select,
  input  logic        cmd_mode,
  input  logic        cmd_wide,
  input  logic        cmd_use_carry,
  input  logic [2:0]  cmd_src_a,
  input  logic [2:0]  cmd_src_b,
  input  logic [2:0]  cmd_dst,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_select,
  output logic        alu_mode,
  output logic        alu_carry_in,
  input  logic [15:0] alu_result,
  input  logic        alu_carry_out,
  input  logic        alu_compare,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_carry,
  output logic        rsp_compare,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC_LO, S_EXEC_HI, S_RESP} state_t;

  state_t      r_state;
  logic [15:0] r_rf [0:7];
  logic        r_run;
  logic        r_carry_flag;
  logic        r_cmp_acc;
  logic        r_wide;
  logic        r_mode;
  logic [2:0]  r_dst;
  logic [2:0]  r_src_a_hi;
  logic [2:0]  r_src_b_hi;

  logic [2:0]  w_src_a;
  logic [2:0]  w_src_b;
  logic [2:0]  w_dst;
  logic        w_accept;

  // Wide commands operate on even/odd register pairs, so bit 0 is dropped.
  assign w_src_a  = cmd_wide ? {cmd_src_a[2:1], 1'b0} : cmd_src_a;
  assign w_src_b  = cmd_wide ? {cmd_src_b[2:1], 1'b0} : cmd_src_b;
  assign w_dst    = cmd_wide ? {cmd_dst[2:1], 1'b0}   : cmd_dst;

  // r_run keeps cmd_ready low while in reset; loads take priority over commands.
  assign cmd_ready   = r_run && (r_state == S_IDLE) && !ld_valid;
  assign w_accept    = cmd_valid && cmd_ready;
  assign busy        = (r_state != S_IDLE);
  assign rsp_valid   = (r_state == S_RESP);
  assign rsp_carry   = r_carry_flag;
  assign rsp_compare = r_cmp_acc;
  assign rd_data     = r_rf[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_run        <= 1'b0;
      for (int i = 0; i < 8; i++) r_rf[i] <= 16'h0000;
      r_carry_flag <= 1'b0;
      r_cmp_acc    <= 1'b0;
      r_wide       <= 1'b0;
      r_mode       <= 1'b0;
      r_dst        <= 3'd0;
      r_src_a_hi   <= 3'd0;
      r_src_b_hi   <= 3'd0;
      alu_a        <= 16'h0000;
      alu_b        <= 16'h0000;
      alu_select   <= 4'd0;
      alu_mode     <= 1'b0;
      alu_carry_in <= 1'b0;
    end else begin
      r_run <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (ld_valid) begin
            r_rf[ld_addr] <= ld_data;
          end else if (w_accept) begin
            r_wide       <= cmd_wide;
            r_mode       <= cmd_mode;
            r_dst        <= w_dst;
            r_src_a_hi   <= {cmd_src_a[2:1], 1'b1};
            r_src_b_hi   <= {cmd_src_b[2:1], 1'b1};
            alu_a        <= r_rf[w_src_a];
            alu_b        <= r_rf[w_src_b];
            alu_select   <= cmd_select;
            alu_mode     <= cmd_mode;
            alu_carry_in <= cmd_use_carry & r_carry_flag;
            r_state      <= S_EXEC_LO;
          end
        end
        S_EXEC_LO: begin
          r_rf[r_dst] <= alu_result;
          if (!r_mode) r_carry_flag <= alu_carry_out;
          r_cmp_acc <= alu_compare;
          if (r_wide) begin
            // High half reads odd registers; the even write above cannot disturb them.
            alu_a        <= r_rf[r_src_a_hi];
            alu_b        <= r_rf[r_src_b_hi];
            alu_carry_in <= r_mode ? 1'b0 : alu_carry_out;
            r_state      <= S_EXEC_HI;
          end else begin
            r_state <= S_RESP;
          end
        end
        S_EXEC_HI: begin
          r_rf[{r_dst[2:1], 1'b1}] <= alu_result;
          if (!r_mode) r_carry_flag <= alu_carry_out;
          r_cmp_acc <= r_cmp_acc & alu_compare;
          r_state   <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed and random checks of alu_sequencer against a register-file model
// A behavioural ALU drives the DUT's ALU inputs; the model tracks registers, carry and compare per command.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_select;
  logic        cmd_mode;
  logic        cmd_wide;
  logic        cmd_use_carry;
  logic [2:0]  cmd_src_a;
  logic [2:0]  cmd_src_b;
  logic [2:0]  cmd_dst;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_select;
  logic        alu_mode;
  logic        alu_carry_in;
  logic [15:0] alu_result;
  logic        alu_carry_out;
  logic        alu_compare;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_carry;
  logic        rsp_compare;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] rf_m [0:7];
  logic        carry_m;
  logic [15:0] pend_lo, pend_hi;
  logic        pend_carry, pend_cmp, pend_wide;
  logic [2:0]  pend_dst;
  logic        last_carry, last_cmp;

  always #5 clk = ~clk;

  // {carry_out, compare, result}; 1001 add, 0110 sub (arith) / xor (logic), 1011 and, 1110 or, 0000 not-a.
  function automatic logic [17:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] s, input logic m, input logic ci);
    logic [16:0] t;
    logic [15:0] r;
    logic        co;
    t  = 17'd0;
    co = 1'b0;
    r  = a;
    if (m) begin
      case (s)
        4'b0110: r = a ^ b;
        4'b1011: r = a & b;
        4'b1110: r = a | b;
        4'b0000: r = ~a;
        default: r = a;
      endcase
    end else begin
      case (s)
        4'b1001: t = {1'b0, a} + {1'b0, b} + {16'd0, ci};
        4'b0110: t = {1'b0, a} + {1'b0, ~b} + {16'd0, ci};
        default: t = {1'b0, a} + {16'd0, ci};
      endcase
      r  = t[15:0];
      co = t[16];
    end
    return {co, (a == b), r};
  endfunction

  logic [17:0] w_alu;
  assign w_alu         = alu_ref(alu_a, alu_b, alu_select, alu_mode, alu_carry_in);
  assign alu_result    = w_alu[15:0];
  assign alu_compare   = w_alu[16];
  assign alu_carry_out = w_alu[17];

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_select(cmd_select),
    .cmd_mode(cmd_mode), .cmd_wide(cmd_wide), .cmd_use_carry(cmd_use_carry),
    .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_mode(alu_mode),
    .alu_carry_in(alu_carry_in), .alu_result(alu_result),
    .alu_carry_out(alu_carry_out), .alu_compare(alu_compare),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_carry(rsp_carry),
    .rsp_compare(rsp_compare), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
    rd_addr = a;
    #1;
    chk(tag, {16'd0, rd_data}, {16'd0, exp});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) rf_m[i] = 16'h0000;
    carry_m = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] a, input logic [15:0] d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    rf_m[a]  = d;
  endtask

  // Presents a command, waits for acceptance and computes the expected outcome from the model.
  task automatic issue(input logic [3:0] sel, input logic m, input logic w, input logic uc,
                       input logic [2:0] sa, input logic [2:0] sb, input logic [2:0] d,
                       output int waits);
    logic [2:0]  la, lb;
    logic [17:0] lo, hi;
    la = w ? {sa[2:1], 1'b0} : sa;
    lb = w ? {sb[2:1], 1'b0} : sb;
    lo = alu_ref(rf_m[la], rf_m[lb], sel, m, uc & carry_m);
    hi = alu_ref(rf_m[la | 3'd1], rf_m[lb | 3'd1], sel, m, m ? 1'b0 : lo[17]);
    pend_wide  = w;
    pend_dst   = w ? {d[2:1], 1'b0} : d;
    pend_lo    = lo[15:0];
    pend_hi    = hi[15:0];
    pend_cmp   = w ? (lo[16] & hi[16]) : lo[16];
    pend_carry = m ? carry_m : (w ? hi[17] : lo[17]);
    cmd_select = sel; cmd_mode = m; cmd_wide = w; cmd_use_carry = uc;
    cmd_src_a = sa; cmd_src_b = sb; cmd_dst = d;
    cmd_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready || waits > 20) break;
      waits++;
    end
    if (!cmd_ready) chk("cmd_accept", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Waits for the response, optionally stalls it, completes the handshake and checks results.
  task automatic finish(input string tag, input int hold);
    int lat;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, pend_wide ? 3 : 2);
    chk({tag, "_rsp_carry"}, {31'd0, rsp_carry}, {31'd0, pend_carry});
    chk({tag, "_rsp_cmp"}, {31'd0, rsp_compare}, {31'd0, pend_cmp});
    last_carry = rsp_carry;
    last_cmp   = rsp_compare;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, "_hold_ready"}, {31'd0, cmd_ready}, 32'd0);
      chk({tag, "_hold_flags"}, {30'd0, rsp_carry, rsp_compare}, {30'd0, last_carry, last_cmp});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_idle"}, {30'd0, busy, rsp_valid}, 32'd0);
    chk({tag, "_ready_after"}, {31'd0, cmd_ready}, 32'd1);
    rf_m[pend_dst] = pend_lo;
    if (pend_wide) rf_m[pend_dst | 3'd1] = pend_hi;
    carry_m = pend_carry;
    chk_reg({tag, "_dst_lo"}, pend_dst, pend_lo);
    if (pend_wide) chk_reg({tag, "_dst_hi"}, pend_dst | 3'd1, pend_hi);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [3:0] sels [0:5];
    sels[0] = 4'b1001; sels[1] = 4'b0110; sels[2] = 4'b1011;
    sels[3] = 4'b1110; sels[4] = 4'b0000; sels[5] = 4'b0011;
    rst_n = 1'b0;
    ld_valid = 1'b0; ld_addr = 3'd0; ld_data = 16'h0; rd_addr = 3'd0;
    cmd_valid = 1'b0; cmd_select = 4'd0; cmd_mode = 1'b0; cmd_wide = 1'b0;
    cmd_use_carry = 1'b0; cmd_src_a = 3'd0; cmd_src_b = 3'd0; cmd_dst = 3'd0;
    rsp_ready = 1'b0;
    model_reset();
    #12;
    chk("rst_flags", {27'd0, busy, rsp_valid, rsp_carry, rsp_compare, cmd_ready}, 32'd0);
    chk("rst_alu_ops", {alu_a, alu_b}, 32'd0);
    chk("rst_alu_ctl", {26'd0, alu_select, alu_mode, alu_carry_in}, 32'd0);
    chk_reg("rst_r0", 3'd0, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);

    do_load(3'd0, 16'h00AA);
    do_load(3'd1, 16'h0003);
    issue(4'b1001, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 3'd2, w);
    chk("midop_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midop_abort", {30'd0, busy, rsp_valid}, 32'd0);
    chk_reg("midop_r2", 3'd2, 16'h0000);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_load(3'd0, 16'h1234);
    chk_reg("load_r0", 3'd0, 16'h1234);

    do_load(3'd0, 16'hFFFF);
    do_load(3'd1, 16'h0001);
    issue(4'b1001, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 3'd2, w);
    finish("narrow", 0);
    chk_reg("narrow_r2", 3'd2, 16'h0000);
    chk("narrow_carry", {31'd0, last_carry}, 32'd1);

    do_load(3'd1, 16'h0000);
    do_load(3'd2, 16'h0001);
    do_load(3'd3, 16'h0000);
    issue(4'b1001, 1'b0, 1'b1, 1'b0, 3'd0, 3'd2, 3'd4, w);
    finish("wide", 0);
    chk_reg("wide_r4", 3'd4, 16'h0000);
    chk_reg("wide_r5", 3'd5, 16'h0001);
    chk("wide_carry", {31'd0, last_carry}, 32'd0);

    do_load(3'd1, 16'h0001);
    issue(4'b1001, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 3'd6, w);
    finish("setc", 0);
    do_load(3'd0, 16'h00FF);
    do_load(3'd1, 16'h0F0F);
    issue(4'b0110, 1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 3'd3, w);
    finish("xor", 0);
    chk_reg("xor_r3", 3'd3, 16'h0FF0);
    chk("xor_carry", {31'd0, last_carry}, 32'd1);

    do_load(3'd2, 16'h0005);
    do_load(3'd3, 16'h0005);
    issue(4'b0110, 1'b0, 1'b0, 1'b1, 3'd2, 3'd3, 3'd7, w);
    finish("bp", 5);

    do_load(3'd1, 16'h0100);
    ld_valid = 1'b1; ld_addr = 3'd0; ld_data = 16'h0042;
    cmd_select = 4'b1001; cmd_mode = 1'b0; cmd_wide = 1'b0; cmd_use_carry = 1'b0;
    cmd_src_a = 3'd0; cmd_src_b = 3'd1; cmd_dst = 3'd5; cmd_valid = 1'b1;
    #1;
    chk("coll_ready_low", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    rf_m[0] = 16'h0042;
    issue(4'b1001, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 3'd5, w);
    chk("coll_wait", w, 0);
    finish("coll", 0);
    chk_reg("coll_r5", 3'd5, 16'h0142);

    for (int n = 0; n < 40; n++) begin
      int nl;
      nl = $urandom_range(0, 2);
      for (int k = 0; k < nl; k++)
        do_load(3'($urandom_range(0, 7)),
                $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 2)));
      issue(sels[$urandom_range(0, 5)], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), w);
      finish("rand", $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
